// File: rtl/ex_mem_skid_if.sv
// Handshake and payload bundle between the execute stage, the EX/MEM skid
// buffer and the memory stage.
//   slave  : the buffer. It takes in_* and out_ready, and drives in_ready and out_*.
//   master : the surrounding pipeline. It drives in_* and out_ready.
// Valid/ready rule, on both sides: a transfer happens on a rising clock edge
// where valid and ready are both high. Once the producer raises valid, it holds
// valid and the payload steady until that transfer happens. The producer never
// waits for ready before raising valid.
interface ex_mem_skid_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic              in_carryout;
  logic              in_overflow;
  logic [RD_W-1:0]   in_rd;
  logic              in_regwrite;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_carryout;
  logic              out_overflow;
  logic              out_zero;
  logic [RD_W-1:0]   out_rd;
  logic              out_regwrite;

  modport slave (
    input  in_valid, in_result, in_carryout, in_overflow, in_rd, in_regwrite,
    output in_ready,
    output out_valid, out_result, out_carryout, out_overflow, out_zero,
    output out_rd, out_regwrite,
    input  out_ready
  );

  modport master (
    output in_valid, in_result, in_carryout, in_overflow, in_rd, in_regwrite,
    input  in_ready,
    input  out_valid, out_result, out_carryout, out_overflow, out_zero,
    input  out_rd, out_regwrite,
    output out_ready
  );
endinterface

// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline boundary: a two-entry skid buffer.
// The head register drives the memory stage. The skid register catches one
// extra entry when the memory stage stalls.
// Ports:
//   clk, rst_n : rising-edge clock; asynchronous active-low reset
//   flush      : synchronous flush. It drops every held entry and overrides
//                all handshakes in the same cycle.
//   bus        : in_* / out_* valid-ready bundle (ex_mem_skid_if.slave)
//   occupancy  : entries held (0..2). This is the raw FSM state encoding.
//   flush_cnt  : saturating count of valid entries discarded by flush
module ex_mem_skid_reg #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int FCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  ex_mem_skid_if.slave      bus,
  output logic [1:0]        occupancy,
  output logic [FCNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              carryout;
    logic              overflow;
    logic              zero;
    logic [RD_W-1:0]   rd;
    logic              regwrite;
  } entry_t;

  state_t state;
  entry_t head;
  entry_t skid;
  entry_t in_ent;

  logic in_fire;
  logic out_fire;
  logic [FCNT_W:0] fsum;

  // The zero flag is computed here, at capture, and stored with the entry.
  // That keeps out_zero a flop output with no in->out combinational path.
  always_comb begin
    in_ent.result   = bus.in_result;
    in_ent.carryout = bus.in_carryout;
    in_ent.overflow = bus.in_overflow;
    in_ent.zero     = (bus.in_result == '0);
    in_ent.rd       = bus.in_rd;
    in_ent.regwrite = bus.in_regwrite;
  end

  // Both handshake outputs decode from state flops only.
  assign bus.in_ready  = (state != TWO);
  assign bus.out_valid = (state != EMPTY);
  assign occupancy     = state;

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  // The extra top bit catches carry-out, so the counter clamps instead of wrapping.
  assign fsum = {1'b0, flush_cnt} + {{(FCNT_W-1){1'b0}}, state};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      head      <= '0;
      skid      <= '0;
      flush_cnt <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      head      <= '0;
      skid      <= '0;
      flush_cnt <= fsum[FCNT_W] ? {FCNT_W{1'b1}} : fsum[FCNT_W-1:0];
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            head  <= in_ent;
            state <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            head <= in_ent;
          end else if (in_fire) begin
            skid  <= in_ent;
            state <= TWO;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire) begin
            head  <= skid;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign bus.out_result   = head.result;
  assign bus.out_carryout = head.carryout;
  assign bus.out_overflow = head.overflow;
  assign bus.out_zero     = head.zero;
  assign bus.out_rd       = head.rd;
  assign bus.out_regwrite = head.regwrite;

endmodule
